// File: rtl/fpa_add_pkg.sv
// Shared types and sizing helpers for the pipelined reduced full adder.
package fpa_add_pkg;
  localparam int DEFAULT_N      = 32;
  localparam int DEFAULT_STAGES = 4;

  // Running carry state handed between stages; g/p are group terms over chunks resolved so far.
  typedef struct packed {
    logic carry;
    logic g;
    logic p;
  } stage_flags_t;

  function automatic bit chunk_cfg_ok(input int n, input int stages);
    return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
  endfunction

  function automatic int chunk_width(input int n, input int stages);
    return (stages >= 1) ? n / stages : n;
  endfunction
endpackage

// File: rtl/fpa_add_chunk.sv
// Combinational W-bit chunk adder with chunk generate/propagate and MSB carry-in.
module fpa_add_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         g,
  output logic         p,
  output logic         c_msb,
  output logic         co
);
  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign sum   = full[W-1:0];
  assign co    = full[W];
  assign p     = &(a ^ b);
  // co = g | (p & ci), and a fully propagating chunk cannot generate.
  assign g     = co & ~(p & ci);
  assign c_msb = full[W-1] ^ a[W-1] ^ b[W-1];
endmodule

// File: rtl/pipelined_reduced_full_add.sv
// N-bit add/subtract resolved one W-bit chunk per stage with registered carry hand-off.
// Handshake: a beat moves on valid && ready; a stage loads when empty or when its successor loads.
module pipelined_reduced_full_add
  import fpa_add_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         co,
  output logic         ovf,
  output logic         cp,
  output logic         cg
);
  localparam int W = chunk_width(N, STAGES);

  if (!chunk_cfg_ok(N, STAGES)) begin : g_cfg_check
    $error("pipelined_reduced_full_add: N=%0d must be a multiple of STAGES=%0d with 1 <= STAGES <= N",
           N, STAGES);
  end

  logic [N-1:0]    b_eff;
  logic [STAGES:0] rdy;

  assign b_eff       = b ^ {N{sub}};
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rst_n & rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = (STAGES - k) * W;  // operand bits not yet consumed on entry
    localparam int RW = (k + 1) * W;       // result bits resolved after this stage

    logic          src_v;
    logic [IW-1:0] src_a;
    logic [IW-1:0] src_b;
    logic          src_carry;
    logic          src_g;
    logic          src_p;
    logic [RW-1:0] nxt_res;
    logic [W-1:0]  sum;
    logic          g_c;
    logic          p_c;
    logic          msb_c;
    logic          co_c;

    logic          v_r;
    logic [RW-1:0] res_r;
    stage_flags_t  flg_r;

    if (k == 0) begin : g_src
      assign src_v     = in_valid & in_ready;
      assign src_a     = a;
      assign src_b     = b_eff;
      assign src_carry = ci;
      assign src_g     = 1'b0;
      assign src_p     = 1'b1;
      assign nxt_res   = sum;
    end else begin : g_src
      assign src_v     = g_stage[k-1].v_r;
      assign src_a     = g_stage[k-1].g_skew.a_r;
      assign src_b     = g_stage[k-1].g_skew.b_r;
      assign src_carry = g_stage[k-1].flg_r.carry;
      assign src_g     = g_stage[k-1].flg_r.g;
      assign src_p     = g_stage[k-1].flg_r.p;
      assign nxt_res   = {sum, g_stage[k-1].res_r};
    end

    fpa_add_chunk #(.W(W)) u_chunk (
      .a     (src_a[W-1:0]),
      .b     (src_b[W-1:0]),
      .ci    (src_carry),
      .sum   (sum),
      .g     (g_c),
      .p     (p_c),
      .c_msb (msb_c),
      .co    (co_c)
    );

    assign rdy[k] = ~v_r | rdy[k+1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_r   <= 1'b0;
        res_r <= '0;
        flg_r <= '0;
      end else if (rdy[k]) begin
        v_r <= src_v;
        if (src_v) begin
          res_r <= nxt_res;
          flg_r <= '{carry: co_c, g: g_c | (p_c & src_g), p: p_c & src_p};
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [IW-W-1:0] a_r;
      logic [IW-W-1:0] b_r;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (rdy[k] && src_v) begin
          a_r <= src_a[IW-1:W];
          b_r <= src_b[IW-1:W];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic msb_r;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          msb_r <= 1'b0;
        end else if (rdy[k] && src_v) begin
          msb_r <= msb_c;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign c         = g_stage[STAGES-1].res_r;
  assign co        = g_stage[STAGES-1].flg_r.carry;
  assign ovf       = g_stage[STAGES-1].g_last.msb_r ^ g_stage[STAGES-1].flg_r.carry;
  assign cp        = g_stage[STAGES-1].flg_r.p;
  assign cg        = g_stage[STAGES-1].flg_r.g;
endmodule

// File: tb/tb_pipelined_reduced_full_add.sv
// Directed bench for pipelined_reduced_full_add: latency, flags, streaming order, reset flush.
module tb_pipelined_reduced_full_add;
  localparam int N      = 32;
  localparam int STAGES = 4;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [N-1:0] a         = '0;
  logic [N-1:0] b         = '0;
  logic         ci        = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] c;
  logic         co;
  logic         ovf;
  logic         cp;
  logic         cg;

  int checks = 0;
  int errors = 0;

  // Expected beats: {co, ovf, cp, cg, c}
  logic [35:0] exp_q[$];
  logic        took;
  logic        emitted;

  logic [31:0] va[8]   = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000,
                           32'h0F0F_0F0F, 32'h7FFF_FFFF, 32'h0000_FFFF, 32'hDEAD_BEEF};
  logic [31:0] vb[8]   = '{32'h0000_0002, 32'h0000_0001, 32'h1111_1111, 32'h0000_0001,
                           32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h1234_5678};
  logic        vci[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        vsub[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  pipelined_reduced_full_add #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .co        (co),
    .ovf       (ovf),
    .cp        (cp),
    .cg        (cg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Plain-arithmetic reference, independent of the chunking.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci_m, input logic sub_m);
    logic [31:0] be;
    logic [32:0] full;
    logic [32:0] gen;
    logic [31:0] low;
    be   = y ^ {32{sub_m}};
    full = {1'b0, x} + {1'b0, be} + {32'd0, ci_m};
    gen  = {1'b0, x} + {1'b0, be};
    low  = {1'b0, x[30:0]} + {1'b0, be[30:0]} + {31'd0, ci_m};
    return {full[32], low[31] ^ full[32], &(x ^ be), gen[32], full[31:0]};
  endfunction

  // One clock: drive at the falling edge, then observe both handshakes before the rising edge.
  task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ici, input logic isub, input logic ordy,
                       input logic irst, input logic [35:0] iexp);
    logic [35:0] e;
    @(negedge clk);
    rst_n     = irst;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    ci        = ici;
    sub       = isub;
    out_ready = ordy;
    #1;
    took    = in_valid && in_ready;
    emitted = out_valid && out_ready;
    if (emitted) begin
      if (exp_q.size() == 0) begin
        check("stale_out", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'(c), 64'(e[31:0]));
        check("flags", 64'({co, ovf, cp, cg}), 64'(e[35:32]));
      end
    end
    if (took) exp_q.push_back(iexp);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ordy, 1'b1, 36'd0);
  endtask

  task automatic latency_vec(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                             input logic ici, input logic isub, input logic [35:0] iexp);
    cycle(1'b1, ia, ib, ici, isub, 1'b1, 1'b1, iexp);
    check({tag, "_accept"}, 64'(took), 64'd1);
    for (int i = 1; i < STAGES; i++) begin
      idle(1'b1);
      check({tag, "_early"}, 64'(out_valid), 64'd0);
    end
    idle(1'b1);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    int idx;
    int nout;
    int nacc;
    int first;

    // Reset: in_ready low and in_valid ignored while rst_n=0.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 36'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
    end
    idle(1'b1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'({c, co, ovf, cp, cg}), 64'd0);
    check("rst_release_ready", 64'(in_ready), 64'd1);

    // Directed vectors, expected {co,ovf,cp,cg,c} worked out by hand.
    latency_vec("v_ff_plus_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {4'b0000, 32'h0000_0100});
    latency_vec("v_ripple",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {4'b1010, 32'h0000_0000});
    latency_vec("v_5_minus_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {4'b0000, 32'hFFFF_FFFE});
    latency_vec("v_pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {4'b0100, 32'h8000_0000});
    latency_vec("v_neg_ovf",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {4'b1101, 32'h0000_0000});
    latency_vec("v_0_minus_0", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, {4'b1010, 32'h0000_0000});

    // Streaming with pseudo-random backpressure.
    idx  = 0;
    nout = 0;
    for (int cyc = 0; cyc < 300 && nout < 8; cyc++) begin
      if (idx < 8)
        cycle(1'b1, va[idx], vb[idx], vci[idx], vsub[idx], 1'($urandom_range(0, 1)), 1'b1,
              model(va[idx], vb[idx], vci[idx], vsub[idx]));
      else
        idle(1'($urandom_range(0, 1)));
      if (took) idx++;
      if (emitted) nout++;
    end
    check("stream_in_count", 64'(idx), 64'd8);
    check("stream_out_count", 64'(nout), 64'd8);
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    // Full throughput: one beat per cycle after the fill latency.
    nacc  = 0;
    nout  = 0;
    first = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8)
        cycle(1'b1, vb[cyc], va[cyc], vsub[cyc], vci[cyc], 1'b1, 1'b1,
              model(vb[cyc], va[cyc], vsub[cyc], vci[cyc]));
      else
        idle(1'b1);
      if (took) nacc++;
      if (emitted) begin
        if (first < 0) first = cyc;
        nout++;
      end
    end
    check("tput_accepts", 64'(nacc), 64'd8);
    check("tput_first_out", 64'(first), 64'(STAGES));
    check("tput_outs", 64'(nout), 64'd8);

    // Reset with three beats in flight: they must never appear.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, va[i], vb[i], vci[i], vsub[i], 1'b1, 1'b1, model(va[i], vb[i], vci[i], vsub[i]));
    cycle(1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 36'd0);
    check("flush_in_ready_low", 64'(in_ready), 64'd0);
    check("flush_took", 64'(took), 64'd0);
    exp_q.delete();
    idle(1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_outputs", 64'({c, co, ovf, cp, cg}), 64'd0);
    check("flush_in_ready_high", 64'(in_ready), 64'd1);
    nout = 0;
    for (int i = 0; i < 2 * STAGES; i++) begin
      idle(1'b1);
      if (emitted) nout++;
    end
    check("flush_no_stale", 64'(nout), 64'd0);

    latency_vec("v_after_flush", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {4'b0000, 32'h0000_0100});
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
